// File: rtl/spi_flash_responder.sv
// SPI/QSPI flash responder (mode 0) running on the system clock.
// Oversamples SCLK/CS_N/IO, decodes READ/FAST_READ/QUAD_OUT_READ/PAGE_PROGRAM/
// READ_STATUS/WREN/WRDI and forwards byte traffic to a memory-side interface.
// Ports:
//   clk, rst                  system clock, async active-high reset
//   in_sclk, in_cs_n, in_io   SPI pins from the controller (asynchronous)
//   out_io, io_ena            SPI pad outputs and per-pin output enables
//   out_rd_req/out_rd_addr    read byte request; in_rd_data/in_rd_valid reply
//   out_wr_valid/addr/data    programmed byte strobe
//   in_mem_busy               reported as status bit 0
//   out_active, out_underrun  transaction activity / read data late pulse
module spi_flash_responder #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DUMMY_CLKS  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_sclk,
  input  logic        in_cs_n,
  input  logic [3:0]  in_io,
  output logic [3:0]  out_io,
  output logic [3:0]  io_ena,
  output logic        out_rd_req,
  output logic [23:0] out_rd_addr,
  input  logic [7:0]  in_rd_data,
  input  logic        in_rd_valid,
  output logic        out_wr_valid,
  output logic [23:0] out_wr_addr,
  output logic [7:0]  out_wr_data,
  input  logic        in_mem_busy,
  output logic        out_active,
  output logic        out_underrun
);
  localparam int unsigned CNT_W = $clog2(DUMMY_CLKS + 32);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CMD     = 3'd1;
  localparam logic [2:0] S_ADDR    = 3'd2;
  localparam logic [2:0] S_DUMMY   = 3'd3;
  localparam logic [2:0] S_RD_DATA = 3'd4;
  localparam logic [2:0] S_WR_DATA = 3'd5;
  localparam logic [2:0] S_STATUS  = 3'd6;
  localparam logic [2:0] S_IGNORE  = 3'd7;

  localparam logic [7:0] OP_READ = 8'h03;
  localparam logic [7:0] OP_FAST = 8'h0B;
  localparam logic [7:0] OP_QUAD = 8'h6B;
  localparam logic [7:0] OP_PP   = 8'h02;
  localparam logic [7:0] OP_RDSR = 8'h05;
  localparam logic [7:0] OP_WREN = 8'h06;
  localparam logic [7:0] OP_WRDI = 8'h04;

  // Pin synchronizers plus one delay stage for edge detection
  logic [SYNC_STAGES-1:0]      sclk_sync, cs_sync;
  logic [SYNC_STAGES-1:0][3:0] io_sync;
  logic                        sclk_d, cs_d;
  logic                        sclk_s, cs_s;
  logic [3:0]                  io_s;
  logic                        sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic                        unused_io_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      io_sync   <= '0;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b1;
    end else begin
      sclk_sync[0] <= in_sclk;
      cs_sync[0]   <= in_cs_n;
      io_sync[0]   <= in_io;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sclk_sync[i] <= sclk_sync[i-1];
        cs_sync[i]   <= cs_sync[i-1];
        io_sync[i]   <= io_sync[i-1];
      end
      sclk_d <= sclk_s;
      cs_d   <= cs_s;
    end
  end

  assign sclk_s      = sclk_sync[SYNC_STAGES-1];
  assign cs_s        = cs_sync[SYNC_STAGES-1];
  assign io_s        = io_sync[SYNC_STAGES-1];
  assign sclk_rise   = sclk_s & ~sclk_d;
  assign sclk_fall   = ~sclk_s & sclk_d;
  assign cs_rise     = cs_s & ~cs_d;
  assign cs_fall     = ~cs_s & cs_d;
  // Only io[0] carries input data in the supported command set
  assign unused_io_c = ^io_s[3:1];

  logic [2:0]       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [7:0]       opcode, opcode_nxt, sh_in, sh_in_nxt, tx_sr, tx_sr_nxt;
  logic [23:0]      addr, addr_nxt;
  logic [2:0]       tx_cnt, tx_cnt_nxt;
  logic [7:0]       rd_buf, rd_buf_nxt;
  logic             wel, wel_nxt, wren_pend, wren_pend_nxt, wrdi_pend, wrdi_pend_nxt;
  logic             wrote, wrote_nxt;
  logic             rd_buf_vld, rd_buf_vld_nxt, rd_pend, rd_pend_nxt, rd_drop, rd_drop_nxt;
  logic [3:0]       io_nxt, io_ena_nxt;
  logic             rd_req_nxt, wr_valid_nxt, underrun_nxt, active_nxt;
  logic [23:0]      rd_addr_nxt, wr_addr_nxt;
  logic [7:0]       wr_data_nxt;
  logic [7:0]       byte_c, data_c;
  logic [23:0]      addr_c;
  logic             quad_c;

  // State and datapath register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;      cnt <= '0;            opcode <= '0;
      sh_in <= '0;          tx_sr <= '0;          addr <= '0;
      tx_cnt <= '0;         rd_buf <= '0;         wel <= 1'b0;
      wren_pend <= 1'b0;    wrdi_pend <= 1'b0;    wrote <= 1'b0;
      rd_buf_vld <= 1'b0;   rd_pend <= 1'b0;      rd_drop <= 1'b0;
      out_io <= '0;         io_ena <= '0;         out_rd_req <= 1'b0;
      out_rd_addr <= '0;    out_wr_valid <= 1'b0; out_wr_addr <= '0;
      out_wr_data <= '0;    out_active <= 1'b0;   out_underrun <= 1'b0;
    end else begin
      state <= state_nxt;         cnt <= cnt_nxt;             opcode <= opcode_nxt;
      sh_in <= sh_in_nxt;         tx_sr <= tx_sr_nxt;         addr <= addr_nxt;
      tx_cnt <= tx_cnt_nxt;       rd_buf <= rd_buf_nxt;       wel <= wel_nxt;
      wren_pend <= wren_pend_nxt; wrdi_pend <= wrdi_pend_nxt; wrote <= wrote_nxt;
      rd_buf_vld <= rd_buf_vld_nxt; rd_pend <= rd_pend_nxt;   rd_drop <= rd_drop_nxt;
      out_io <= io_nxt;           io_ena <= io_ena_nxt;       out_rd_req <= rd_req_nxt;
      out_rd_addr <= rd_addr_nxt; out_wr_valid <= wr_valid_nxt; out_wr_addr <= wr_addr_nxt;
      out_wr_data <= wr_data_nxt; out_active <= active_nxt;   out_underrun <= underrun_nxt;
    end
  end

  // Next-state and output decode
  always_comb begin
    state_nxt = state;          cnt_nxt = cnt;              opcode_nxt = opcode;
    sh_in_nxt = sh_in;          tx_sr_nxt = tx_sr;          addr_nxt = addr;
    tx_cnt_nxt = tx_cnt;        rd_buf_nxt = rd_buf;        wel_nxt = wel;
    wren_pend_nxt = wren_pend;  wrdi_pend_nxt = wrdi_pend;  wrote_nxt = wrote;
    rd_buf_vld_nxt = rd_buf_vld; rd_pend_nxt = rd_pend;     rd_drop_nxt = rd_drop;
    io_nxt = out_io;            rd_req_nxt = 1'b0;          rd_addr_nxt = out_rd_addr;
    wr_valid_nxt = 1'b0;        wr_addr_nxt = out_wr_addr;  wr_data_nxt = out_wr_data;
    underrun_nxt = 1'b0;
    byte_c = {sh_in[6:0], io_s[0]};
    addr_c = {addr[22:0], io_s[0]};
    quad_c = (opcode == OP_QUAD);
    data_c = quad_c ? {tx_sr[3:0], 4'h0} : {tx_sr[6:0], 1'b0};

    // Memory reply: discard a reply owed to a byte that already underran
    if (in_rd_valid) begin
      if (rd_drop) begin
        rd_drop_nxt = 1'b0;
      end else if (rd_pend) begin
        rd_buf_nxt     = in_rd_data;
        rd_buf_vld_nxt = 1'b1;
        rd_pend_nxt    = 1'b0;
      end
    end

    // CS rise wins over any SCLK edge detected in the same cycle
    if (cs_rise) begin
      state_nxt = S_IDLE;
      if (wren_pend) wel_nxt = 1'b1;
      if (wrdi_pend || wrote) wel_nxt = 1'b0;
      wren_pend_nxt = 1'b0; wrdi_pend_nxt = 1'b0; wrote_nxt = 1'b0;
      rd_pend_nxt = 1'b0;   rd_drop_nxt = 1'b0;   rd_buf_vld_nxt = 1'b0;
    end else if (cs_fall) begin
      state_nxt = S_CMD; cnt_nxt = '0; sh_in_nxt = '0; tx_cnt_nxt = '0;
    end else begin
      case (state)
        S_CMD: if (sclk_rise) begin
          sh_in_nxt = byte_c;
          cnt_nxt   = cnt + CNT_W'(1);
          if (cnt == CNT_W'(7)) begin
            cnt_nxt = '0; opcode_nxt = byte_c; tx_cnt_nxt = '0;
            case (byte_c)
              OP_READ, OP_FAST, OP_QUAD: state_nxt = S_ADDR;
              OP_PP:   state_nxt = wel ? S_ADDR : S_IGNORE;
              OP_RDSR: state_nxt = S_STATUS;
              OP_WREN: begin wren_pend_nxt = 1'b1; wrdi_pend_nxt = 1'b0; state_nxt = S_IGNORE; end
              OP_WRDI: begin wrdi_pend_nxt = 1'b1; wren_pend_nxt = 1'b0; state_nxt = S_IGNORE; end
              default: state_nxt = S_IGNORE;
            endcase
          end
        end
        S_ADDR: if (sclk_rise) begin
          addr_nxt = addr_c;
          cnt_nxt  = cnt + CNT_W'(1);
          if (cnt == CNT_W'(23)) begin
            cnt_nxt = '0;
            if (opcode == OP_PP) begin
              state_nxt = S_WR_DATA;
            end else begin
              state_nxt      = (opcode == OP_READ) ? S_RD_DATA : S_DUMMY;
              rd_req_nxt     = 1'b1;
              rd_addr_nxt    = addr_c;
              rd_pend_nxt    = 1'b1;
              rd_buf_vld_nxt = 1'b0;
            end
          end
        end
        S_DUMMY: if (sclk_rise) begin
          cnt_nxt = cnt + CNT_W'(1);
          if (cnt == CNT_W'(DUMMY_CLKS - 1)) begin
            cnt_nxt   = '0;
            state_nxt = S_RD_DATA;
          end
        end
        S_RD_DATA, S_STATUS: if (sclk_fall) begin
          // Byte boundary: load a fresh byte, otherwise keep shifting
          if (tx_cnt == 3'd0) begin
            if (state == S_STATUS) begin
              data_c = {6'b0, wel, in_mem_busy};
            end else begin
              if (rd_buf_vld_nxt) begin
                data_c = rd_buf_nxt;
              end else begin
                data_c       = 8'hFF;
                underrun_nxt = 1'b1;
                rd_drop_nxt  = rd_drop_nxt | rd_pend_nxt;
              end
              addr_nxt       = addr + 24'd1;
              rd_req_nxt     = 1'b1;
              rd_addr_nxt    = addr + 24'd1;
              rd_pend_nxt    = 1'b1;
              rd_buf_vld_nxt = 1'b0;
            end
          end
          tx_sr_nxt  = data_c;
          io_nxt     = quad_c ? data_c[7:4] : {2'b00, data_c[7], 1'b0};
          tx_cnt_nxt = (tx_cnt == (quad_c ? 3'd1 : 3'd7)) ? 3'd0 : tx_cnt + 3'd1;
        end
        S_WR_DATA: if (sclk_rise) begin
          sh_in_nxt = byte_c;
          cnt_nxt   = cnt + CNT_W'(1);
          if (cnt == CNT_W'(7)) begin
            cnt_nxt      = '0;
            wr_valid_nxt = 1'b1;
            wr_addr_nxt  = addr;
            wr_data_nxt  = byte_c;
            addr_nxt     = {addr[23:8], addr[7:0] + 8'd1};
            wrote_nxt    = 1'b1;
          end
        end
        S_IDLE, S_IGNORE: ;
        default: state_nxt = S_IDLE;
      endcase
    end

    io_ena_nxt = 4'h0;
    if (state_nxt == S_RD_DATA) io_ena_nxt = (opcode_nxt == OP_QUAD) ? 4'hF : 4'h2;
    else if (state_nxt == S_STATUS) io_ena_nxt = 4'h2;
    if (io_ena_nxt == 4'h0) io_nxt = 4'h0;
    active_nxt = (state_nxt != S_IDLE);
  end

endmodule

// File: tb/tb_spi_flash_responder.sv
// Directed bench for spi_flash_responder: mode-0 SPI controller tasks, a
// simple in-order memory model and pulse monitors, hand-computed expectations.
module tb_spi_flash_responder;
  localparam int unsigned HALF = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_sclk = 1'b0;
  logic        in_cs_n = 1'b1;
  logic [3:0]  in_io = 4'h0;
  logic [3:0]  out_io, io_ena;
  logic        out_rd_req, out_wr_valid, out_active, out_underrun;
  logic [23:0] out_rd_addr, out_wr_addr;
  logic [7:0]  out_wr_data;
  logic [7:0]  in_rd_data = 8'h00;
  logic        in_rd_valid = 1'b0;
  logic        in_mem_busy = 1'b0;

  spi_flash_responder dut (
    .clk(clk), .rst(rst), .in_sclk(in_sclk), .in_cs_n(in_cs_n), .in_io(in_io),
    .out_io(out_io), .io_ena(io_ena), .out_rd_req(out_rd_req), .out_rd_addr(out_rd_addr),
    .in_rd_data(in_rd_data), .in_rd_valid(in_rd_valid), .out_wr_valid(out_wr_valid),
    .out_wr_addr(out_wr_addr), .out_wr_data(out_wr_data), .in_mem_busy(in_mem_busy),
    .out_active(out_active), .out_underrun(out_underrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Memory model and monitors; the memory replies one clk after a request,
  // except the request numbered late_idx which is answered 160 clk late.
  logic [23:0] wr_addr_q[$];
  logic [7:0]  wr_data_q[$];
  logic [23:0] rd_addr_q[$];
  logic [23:0] mq_addr[$];
  int          mq_due[$];
  int          cyc = 0, req_idx = 0, late_idx = -1;
  int          underruns = 0, ena_cnt = 0;
  logic        mem_quad = 1'b0;

  always @(negedge clk) begin
    cyc++;
    in_rd_valid = 1'b0;
    if (out_rd_req) begin
      rd_addr_q.push_back(out_rd_addr);
      mq_addr.push_back(out_rd_addr);
      mq_due.push_back((req_idx == late_idx) ? cyc + 160 : cyc);
      req_idx++;
    end
    if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
      in_rd_data  = mem_quad ? 8'h3C : mq_addr[0][7:0];
      in_rd_valid = 1'b1;
      void'(mq_addr.pop_front());
      void'(mq_due.pop_front());
    end
    if (out_wr_valid) begin
      wr_addr_q.push_back(out_wr_addr);
      wr_data_q.push_back(out_wr_data);
    end
    if (out_underrun) underruns++;
    if (io_ena != 4'h0) ena_cnt++;
  end

  task automatic half_wait();
    repeat (HALF) @(negedge clk);
  endtask

  task automatic cs_low();
    in_cs_n = 1'b0;
    half_wait();
  endtask

  task automatic cs_high();
    half_wait();
    in_cs_n = 1'b1;
    half_wait();
    half_wait();
  endtask

  // Mode 0: drive MOSI while SCLK low, sample MISO just before the rise
  task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      in_io[0] = tx[i];
      half_wait();
      rx[i]   = out_io[1];
      in_sclk = 1'b1;
      half_wait();
      in_sclk = 1'b0;
    end
    in_io[0] = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    logic [7:0] d;
    xfer(b, 8, d);
  endtask

  task automatic qnib(output logic [3:0] nib, output logic [3:0] ena);
    half_wait();
    nib     = out_io;
    ena     = io_ena;
    in_sclk = 1'b1;
    half_wait();
    in_sclk = 1'b0;
  endtask

  task automatic cmd1(input logic [7:0] op);
    cs_low();
    send(op);
    cs_high();
  endtask

  task automatic read_status(output logic [7:0] s);
    cs_low();
    send(8'h05);
    xfer(8'h00, 8, s);
    cs_high();
  endtask

  initial begin
    logic [7:0] rx;
    logic [3:0] nib, ena;
    int wr_base, rd_base, ur_base, ena_base;

    repeat (5) @(negedge clk);
    chk("rst_out_io", 32'(out_io), 32'h0);
    chk("rst_io_ena", 32'(io_ena), 32'h0);
    chk("rst_active", 32'(out_active), 32'h0);
    chk("rst_rd_req", 32'(out_rd_req), 32'h0);
    chk("rst_rd_addr", 32'(out_rd_addr), 32'h0);
    chk("rst_wr_valid", 32'(out_wr_valid), 32'h0);
    chk("rst_wr_addr", 32'(out_wr_addr), 32'h0);
    chk("rst_wr_data", 32'(out_wr_data), 32'h0);
    chk("rst_underrun", 32'(out_underrun), 32'h0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // WREN, status shows WEL; then with memory busy
    cmd1(8'h06);
    read_status(rx);
    chk("status_wel", 32'(rx), 32'h02);
    in_mem_busy = 1'b1;
    read_status(rx);
    chk("status_wel_busy", 32'(rx), 32'h03);
    in_mem_busy = 1'b0;

    // Page program across the page end
    wr_base = wr_addr_q.size();
    cs_low();
    send(8'h02); send(8'h00); send(8'h12); send(8'hFE);
    chk("pp_active", 32'(out_active), 32'h1);
    send(8'hA5); send(8'h5A); send(8'hC3);
    cs_high();
    chk("pp_count", 32'(wr_addr_q.size() - wr_base), 32'd3);
    chk("pp_addr0", 32'(wr_addr_q[wr_base]),   32'h0012FE);
    chk("pp_addr1", 32'(wr_addr_q[wr_base+1]), 32'h0012FF);
    chk("pp_addr2", 32'(wr_addr_q[wr_base+2]), 32'h001200);
    chk("pp_data0", 32'(wr_data_q[wr_base]),   32'hA5);
    chk("pp_data1", 32'(wr_data_q[wr_base+1]), 32'h5A);
    chk("pp_data2", 32'(wr_data_q[wr_base+2]), 32'hC3);
    read_status(rx);
    chk("status_after_pp", 32'(rx), 32'h00);

    // Program without WEL is ignored
    wr_base  = wr_addr_q.size();
    ena_base = ena_cnt;
    cs_low();
    send(8'h02); send(8'h00); send(8'h00); send(8'h10); send(8'h11); send(8'h22);
    cs_high();
    chk("pp_nowel_count", 32'(wr_addr_q.size() - wr_base), 32'd0);
    chk("pp_nowel_ena", 32'(ena_cnt - ena_base), 32'd0);

    // READ across the 24-bit wrap
    rd_base = rd_addr_q.size();
    ur_base = underruns;
    cs_low();
    send(8'h03); send(8'hFF); send(8'hFF); send(8'hFE);
    xfer(8'h00, 8, rx); chk("rd_byte0", 32'(rx), 32'hFE);
    xfer(8'h00, 8, rx); chk("rd_byte1", 32'(rx), 32'hFF);
    xfer(8'h00, 8, rx); chk("rd_byte2", 32'(rx), 32'h00);
    cs_high();
    chk("rd_addr0", 32'(rd_addr_q[rd_base]),   32'hFFFFFE);
    chk("rd_addr1", 32'(rd_addr_q[rd_base+1]), 32'hFFFFFF);
    chk("rd_addr2", 32'(rd_addr_q[rd_base+2]), 32'h000000);
    chk("rd_no_underrun", 32'(underruns - ur_base), 32'd0);

    // Quad output read with dummy clocks
    mem_quad = 1'b1;
    rd_base  = rd_addr_q.size();
    cs_low();
    send(8'h6B); send(8'h00); send(8'h01); send(8'h00);
    ena_base = ena_cnt;
    xfer(8'h00, 7, rx);
    chk("quad_dummy_ena", 32'(ena_cnt - ena_base), 32'd0);
    xfer(8'h00, 1, rx);
    qnib(nib, ena);
    chk("quad_hi_nib", 32'(nib), 32'h3);
    chk("quad_hi_ena", 32'(ena), 32'hF);
    qnib(nib, ena);
    chk("quad_lo_nib", 32'(nib), 32'hC);
    chk("quad_lo_ena", 32'(ena), 32'hF);
    cs_high();
    mem_quad = 1'b0;
    chk("quad_addr", 32'(rd_addr_q[rd_base]), 32'h000100);
    chk("quad_ena_end", 32'(io_ena), 32'h0);

    // FAST_READ with the second byte's data arriving too late
    late_idx = req_idx + 1;
    ur_base  = underruns;
    cs_low();
    send(8'h0B); send(8'h00); send(8'h00); send(8'h10);
    send(8'h00);
    xfer(8'h00, 8, rx); chk("fast_byte0", 32'(rx), 32'h10);
    xfer(8'h00, 8, rx); chk("fast_byte1_ff", 32'(rx), 32'hFF);
    cs_high();
    late_idx = -1;
    chk("fast_underrun", 32'(underruns - ur_base), 32'd1);

    // Program aborted after 5 data bits: no write, WEL kept
    cmd1(8'h06);
    wr_base = wr_addr_q.size();
    cs_low();
    send(8'h02); send(8'h00); send(8'h00); send(8'h20);
    xfer(8'hFF, 5, rx);
    cs_high();
    chk("abort_no_write", 32'(wr_addr_q.size() - wr_base), 32'd0);
    chk("abort_active", 32'(out_active), 32'h0);
    chk("abort_io_ena", 32'(io_ena), 32'h0);
    read_status(rx);
    chk("abort_wel_kept", 32'(rx), 32'h02);
    cmd1(8'h04);
    read_status(rx);
    chk("wrdi_status", 32'(rx), 32'h00);

    // Reset in the middle of read data
    cmd1(8'h06);
    cs_low();
    send(8'h03); send(8'h00); send(8'h00); send(8'h40);
    xfer(8'h00, 3, rx);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("mid_rst_out_io", 32'(out_io), 32'h0);
    chk("mid_rst_io_ena", 32'(io_ena), 32'h0);
    chk("mid_rst_active", 32'(out_active), 32'h0);
    chk("mid_rst_rd_addr", 32'(out_rd_addr), 32'h0);
    in_cs_n = 1'b1;
    in_sclk = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    read_status(rx);
    chk("rst_clears_wel", 32'(rx), 32'h00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
